multi_clock_generator: RTL and testbench

Parametrised successor to the single-channel game clock divider. Generates NUM_CH independent timebases from the board clock. Each channel has a run-time programmable period and produces:
- a one-cycle tick enable;
- a square-wave level output.

Game logic, display refresh and sound sequencing each use their own channel.

---
 rtl/multi_clock_generator_if.sv | 41 ++++
 rtl/multi_clock_generator.sv | 134 +++++++++++++
 tb/tb_multi_clock_generator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_clock_generator_if.sv
// ---------------------------------------------------------------------------
// multi_clock_generator_if
//   Configuration, control and output bundle for multi_clock_generator.
//   master : drives cfg_*, run, restart; observes tick, level, done
//   slave  : the generator itself
// Signals:
//   cfg_we       period write strobe (one cycle)
//   cfg_ch       target channel of the write
//   cfg_div      new period in clock cycles
//   cfg_oneshot  new one-shot mode bit, written together with cfg_div
//   run          per-channel count enable (level)
//   restart      per-channel synchronous restart pulse
//   tick         per-channel one-cycle pulse once per period
//   level        per-channel square wave
//   done         per-channel one-shot completion flag
// ---------------------------------------------------------------------------
interface multi_clock_generator_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] restart;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] done;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_oneshot, run, restart,
    input  tick, level, done
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_oneshot, run, restart,
    output tick, level, done
  );
endinterface

// File: rtl/multi_clock_generator.sv
// ---------------------------------------------------------------------------
// multi_clock_generator
//   NUM_CH independent programmable timebases derived from the board clock.
//   Each channel counts running edges up to its effective period
//   Pe = max(P, 1) and emits a one-cycle tick plus a square-wave level that
//   is high for Pe>>1 cycles starting with the tick cycle.
// Ports:
//   clock  board clock, all logic on the rising edge
//   reset  asynchronous, active-high reset
//   bus    multi_clock_generator_if.slave (cfg_*, run, restart in;
//          tick, level, done out)
// Optional feature:
//   CLKGEN_ONESHOT_EN  when defined, each channel has a one-shot mode bit and
//                      a done flag; otherwise all channels are periodic,
//                      cfg_oneshot is ignored and done is tied low.
// ---------------------------------------------------------------------------
module multi_clock_generator #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 50000000
) (
  input logic clock,
  input logic reset,
  multi_clock_generator_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_done;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_level;
    logic [CNT_W-1:0] w_pe;
    logic [CNT_W-1:0] w_half;
    logic             w_wrSel;
    logic             w_wrap;
    logic             w_halfHit;
    logic             w_hold;

    // A zero period behaves like a period of one.
    assign w_pe      = (r_period == '0) ? CNT_W'(1) : r_period;
    assign w_half    = w_pe >> 1;
    // Comparing against this channel's index also discards out-of-range cfg_ch.
    assign w_wrSel   = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));
    // >= rather than == so a shrunk period still wraps on the next edge.
    assign w_wrap    = (r_cnt >= (w_pe - CNT_W'(1)));
    // For Pe = 1 this compares against all-ones, but the wrap branch wins.
    assign w_halfHit = (r_cnt == (w_half - CNT_W'(1)));

    // Period register: new value is used from the edge after the write.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_period <= CNT_W'(DEFAULT_DIV);
      end else if (w_wrSel) begin
        r_period <= bus.cfg_div;
      end
    end

    // Counter, tick and level, with restart > one-shot hold > run gating.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_cnt   <= '0;
        r_tick  <= 1'b0;
        r_level <= 1'b0;
      end else if (bus.restart[gi]) begin
        r_cnt   <= '0;
        r_tick  <= 1'b0;
        r_level <= 1'b0;
      end else if (w_hold || !bus.run[gi]) begin
        r_tick  <= 1'b0;
      end else if (w_wrap) begin
        r_cnt   <= '0;
        r_tick  <= 1'b1;
        r_level <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_tick  <= 1'b0;
        if (w_halfHit) begin
          r_level <= 1'b0;
        end
      end
    end

`ifdef CLKGEN_ONESHOT_EN
    logic r_os;
    logic r_done;

    assign w_hold = r_os && r_done;

    // Mode bit and completion flag; a write clearing the mode bit also
    // clears done, even if the same edge would have completed the shot.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_os   <= 1'b0;
        r_done <= 1'b0;
      end else begin
        if (w_wrSel) begin
          r_os <= bus.cfg_oneshot;
        end
        if (w_wrSel && !bus.cfg_oneshot) begin
          r_done <= 1'b0;
        end else if (bus.restart[gi]) begin
          r_done <= 1'b0;
        end else if (!w_hold && bus.run[gi] && w_wrap && r_os) begin
          r_done <= 1'b1;
        end
      end
    end

    assign w_done[gi] = r_done;
`else
    assign w_hold = 1'b0;
`endif

    assign w_tick[gi]  = r_tick;
    assign w_level[gi] = r_level;
  end

`ifndef CLKGEN_ONESHOT_EN
  logic w_unusedOneshot;
  assign w_unusedOneshot = bus.cfg_oneshot;
  assign w_done          = '0;
`endif

  assign bus.tick  = w_tick;
  assign bus.level = w_level;
  assign bus.done  = w_done;

endmodule

// File: tb/tb_multi_clock_generator.sv
// ---------------------------------------------------------------------------
// tb_multi_clock_generator
//   Self-checking bench for multi_clock_generator. Three channels are used so
//   that an out-of-range cfg_ch (3) is representable. Expected outputs come
//   from a per-edge reference model and travel through a scoreboard queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_clock_generator;

  localparam int NUM_CH      = 3;
  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 6;
  localparam int CH_W        = 2;
`ifdef CLKGEN_ONESHOT_EN
  localparam bit OS_EN = 1'b1;
`else
  localparam bit OS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] done;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  multi_clock_generator_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  multi_clock_generator #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int failCount  = 0;
  exp_t expQ[$];

  // Reference model state
  int                mP[NUM_CH];
  int                mCnt[NUM_CH];
  logic [NUM_CH-1:0] mOs;
  logic [NUM_CH-1:0] mDone;
  logic [NUM_CH-1:0] mTick;
  logic [NUM_CH-1:0] mLevel;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s t=%0t actual=%0h expected=%0h", tag, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      mP[i]   = DEFAULT_DIV;
      mCnt[i] = 0;
    end
    mOs = '0; mDone = '0; mTick = '0; mLevel = '0;
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic modelStep(input logic we, input logic [CH_W-1:0] ch,
                           input logic [CNT_W-1:0] div, input logic os,
                           input logic [NUM_CH-1:0] runV,
                           input logic [NUM_CH-1:0] rstV);
    for (int i = 0; i < NUM_CH; i++) begin
      int pe;
      int h;
      pe = (mP[i] == 0) ? 1 : mP[i];
      h  = pe / 2;
      if (rstV[i]) begin
        mCnt[i] = 0; mTick[i] = 1'b0; mLevel[i] = 1'b0; mDone[i] = 1'b0;
      end else if (mOs[i] && mDone[i]) begin
        mTick[i] = 1'b0;
      end else if (!runV[i]) begin
        mTick[i] = 1'b0;
      end else if (mCnt[i] >= pe - 1) begin
        mCnt[i] = 0; mTick[i] = 1'b1; mLevel[i] = 1'b1;
        if (mOs[i]) mDone[i] = 1'b1;
      end else begin
        if (mCnt[i] == h - 1) mLevel[i] = 1'b0;
        mCnt[i] = mCnt[i] + 1;
        mTick[i] = 1'b0;
      end
      if (we && (int'(ch) == i)) begin
        mP[i] = int'(div);
        if (OS_EN) begin
          mOs[i] = os;
          if (!os) mDone[i] = 1'b0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, queue the model's prediction, then compare
  // the DUT outputs 1 ns after the edge.
  task automatic applyStimulus(input logic we, input logic [CH_W-1:0] ch,
                               input logic [CNT_W-1:0] div, input logic os,
                               input logic [NUM_CH-1:0] runV,
                               input logic [NUM_CH-1:0] rstV, input string tag);
    exp_t e;
    bus.cfg_we      = we;
    bus.cfg_ch      = ch;
    bus.cfg_div     = div;
    bus.cfg_oneshot = os;
    bus.run         = runV;
    bus.restart     = rstV;
    modelStep(we, ch, div, os, runV, rstV);
    e.tick  = mTick;
    e.level = mLevel;
    e.done  = mDone;
    expQ.push_back(e);
    @(posedge clock);
    #1;
    if (expQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, ".tick"},  32'(bus.tick),  32'(e.tick));
      checkOutput({tag, ".level"}, 32'(bus.level), 32'(e.level));
      checkOutput({tag, ".done"},  32'(bus.done),  32'(e.done));
    end
  endtask

  task automatic idle(input int n, input logic [NUM_CH-1:0] runV, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, '0, 1'b0, runV, '0, tag);
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0; bus.cfg_oneshot = 1'b0;
    bus.run = '0; bus.restart = '0;
    reset = 1'b1;
    modelReset();
    #23;
    checkOutput("reset.tick",  32'(bus.tick),  32'd0);
    checkOutput("reset.level", 32'(bus.level), 32'd0);
    checkOutput("reset.done",  32'(bus.done),  32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Period 4 on channel 0: ticks every 4 edges, level 2 high / 2 low.
    applyStimulus(1'b1, 2'd0, 16'd4, 1'b0, 3'b000, 3'b000, "wrP4");
    idle(13, 3'b001, "p4");

    // Channel 2 at its default period.
    idle(14, 3'b100, "dflt");

    // Period 5 with a pause: phase frozen while run is low.
    applyStimulus(1'b1, 2'd1, 16'd5, 1'b0, 3'b000, 3'b010, "wrP5");
    idle(7, 3'b010, "pauseA");
    idle(3, 3'b000, "pauseB");
    idle(8, 3'b010, "pauseC");

    // Shrink from 10 to 4 while cnt is already past the new wrap point.
    applyStimulus(1'b1, 2'd0, 16'd10, 1'b0, 3'b000, 3'b001, "wrP10");
    idle(7, 3'b001, "shrinkA");
    applyStimulus(1'b1, 2'd0, 16'd4, 1'b0, 3'b001, 3'b000, "shrinkWr");
    idle(6, 3'b001, "shrinkB");

    // Degenerate periods 0 and 1.
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b0, 3'b000, 3'b000, "wrP0");
    applyStimulus(1'b1, 2'd2, 16'd1, 1'b0, 3'b000, 3'b000, "wrP1");
    idle(5, 3'b110, "p0p1");

    // Out-of-range channel write must change nothing.
    applyStimulus(1'b1, 2'd3, 16'd2, 1'b1, 3'b111, 3'b000, "badCh");
    idle(8, 3'b111, "badChRun");

    // Restart coinciding with a wrap, and a write with a restart together.
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 3'b001, 3'b001, "rstA");
    idle(3, 3'b001, "rstB");
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 3'b001, 3'b001, "rstWrap");
    applyStimulus(1'b1, 2'd1, 16'd3, 1'b0, 3'b010, 3'b010, "wrRst");
    idle(7, 3'b011, "wrRstRun");

    // Asynchronous reset mid-count.
    idle(3, 3'b111, "preRst");
    reset = 1'b1;
    #1;
    checkOutput("asyncRst.tick",  32'(bus.tick),  32'd0);
    checkOutput("asyncRst.level", 32'(bus.level), 32'd0);
    checkOutput("asyncRst.done",  32'(bus.done),  32'd0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    idle(13, 3'b101, "postRst");

`ifdef CLKGEN_ONESHOT_EN
    // One-shot with period 3: a single tick, then done until restart.
    applyStimulus(1'b1, 2'd0, 16'd3, 1'b1, 3'b000, 3'b001, "osWr");
    idle(8, 3'b001, "osRun");
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 3'b001, 3'b001, "osRestart");
    idle(6, 3'b001, "osRearm");
    applyStimulus(1'b1, 2'd0, 16'd3, 1'b0, 3'b001, 3'b000, "osClear");
    idle(6, 3'b001, "osPeriodic");
`endif

    // Random traffic against the model.
    for (int k = 0; k < 80; k++) begin
      logic [NUM_CH-1:0] r;
      for (int b = 0; b < NUM_CH; b++) r[b] = ($urandom_range(0, 9) == 0);
      applyStimulus(($urandom_range(0, 4) == 0), CH_W'($urandom_range(0, 3)),
                    CNT_W'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    NUM_CH'($urandom_range(0, 7)), r, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
